// File: rtl/lot_pkg.sv
// Shared types and default parameters for the parking-lot occupancy tracker.
package lot_pkg;

  localparam int CNT_W_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [3:0] {
    ST_RESYNC = 4'd0,
    ST_IDLE   = 4'd1,
    ST_EN1    = 4'd2,
    ST_EN2    = 4'd3,
    ST_EN3    = 4'd4,
    ST_EX1    = 4'd5,
    ST_EX2    = 4'd6,
    ST_EX3    = 4'd7,
    ST_FAULT  = 4'd8
  } state_t;

endpackage

// File: rtl/lot_tracker_gate_fsm.sv
// Sensor synchronizers and gate-sequence FSM; emits registered one-cycle
// entry, exit and fault pulses.
module gate_fsm
  import lot_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sd1,
  input  logic sd2,
  output logic entry_evt,
  output logic exit_evt,
  output logic fault_evt
);

  logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
  logic [SYNC_STAGES-1:0] sync2_q, sync2_d;
  logic [SYNC_STAGES-1:0] flush_q, flush_d;
  logic [1:0]             s;
  logic                   flushed;
  state_t                 state_q, state_d;
  logic                   entry_q, entry_d;
  logic                   exit_q, exit_d;
  logic                   fault_q, fault_d;

  // flush_q marks when the chain holds real sensor samples rather than the reset preset
  always_comb begin
    sync1_d = {sync1_q[SYNC_STAGES-2:0], sd1};
    sync2_d = {sync2_q[SYNC_STAGES-2:0], sd2};
    flush_d = {flush_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= {SYNC_STAGES{1'b1}};
      sync2_q <= {SYNC_STAGES{1'b1}};
      flush_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      flush_q <= flush_d;
    end
  end

  assign s       = {sync1_q[SYNC_STAGES-1], sync2_q[SYNC_STAGES-1]};
  assign flushed = flush_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESYNC;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESYNC: begin
        if (flushed && (s == 2'b11)) state_d = ST_IDLE;
        else                         state_d = ST_RESYNC;
      end
      ST_IDLE: case (s)
        2'b11:   state_d = ST_IDLE;
        2'b01:   state_d = ST_EN1;
        2'b10:   state_d = ST_EX1;
        default: state_d = ST_FAULT;
      endcase
      ST_EN1: case (s)
        2'b01:   state_d = ST_EN1;
        2'b00:   state_d = ST_EN2;
        2'b11:   state_d = ST_IDLE;
        default: state_d = ST_FAULT;
      endcase
      ST_EN2: case (s)
        2'b00:   state_d = ST_EN2;
        2'b10:   state_d = ST_EN3;
        2'b01:   state_d = ST_EN1;
        default: state_d = ST_FAULT;
      endcase
      ST_EN3: case (s)
        2'b10:   state_d = ST_EN3;
        2'b11:   state_d = ST_IDLE;
        2'b00:   state_d = ST_EN2;
        default: state_d = ST_FAULT;
      endcase
      ST_EX1: case (s)
        2'b10:   state_d = ST_EX1;
        2'b00:   state_d = ST_EX2;
        2'b11:   state_d = ST_IDLE;
        default: state_d = ST_FAULT;
      endcase
      ST_EX2: case (s)
        2'b00:   state_d = ST_EX2;
        2'b01:   state_d = ST_EX3;
        2'b10:   state_d = ST_EX1;
        default: state_d = ST_FAULT;
      endcase
      ST_EX3: case (s)
        2'b01:   state_d = ST_EX3;
        2'b11:   state_d = ST_IDLE;
        2'b00:   state_d = ST_EX2;
        default: state_d = ST_FAULT;
      endcase
      ST_FAULT: begin
        if (s == 2'b11) state_d = ST_IDLE;
        else            state_d = ST_FAULT;
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  // Events fire on the transition itself, so each is a single-cycle pulse
  always_comb begin
    entry_d = (state_q == ST_EN3) && (state_d == ST_IDLE);
    exit_d  = (state_q == ST_EX3) && (state_d == ST_IDLE);
    fault_d = (state_q != ST_FAULT) && (state_d == ST_FAULT);
  end

  assign entry_evt = entry_q;
  assign exit_evt  = exit_q;
  assign fault_evt = fault_q;

endmodule

// File: rtl/lot_tracker.sv
// Parking-lot occupancy tracker: saturating car count and error pulse
// driven by the gate sequence FSM.
module lot_tracker
  import lot_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SD1,
  input  logic             SD2,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             entry_evt, exit_evt, fault_evt;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  gate_fsm #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_gate_fsm (
    .clk       (clk),
    .rst       (rst),
    .sd1       (SD1),
    .sd2       (SD2),
    .entry_evt (entry_evt),
    .exit_evt  (exit_evt),
    .fault_evt (fault_evt)
  );

  // Saturate instead of wrapping; hitting either bound is reported as an error
  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (fault_evt) begin
      err_d = 1'b1;
    end else if (entry_evt) begin
      if (count_q == CNT_MAX) err_d   = 1'b1;
      else                    count_d = count_q + CNT_ONE;
    end else if (exit_evt) begin
      if (count_q == {CNT_W{1'b0}}) err_d   = 1'b1;
      else                          count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_lot_tracker.sv
// Randomized self-checking bench for lot_tracker against a path-walking
// reference model with a fixed three-cycle output delay.
module tb_lot_tracker;

  localparam int MAXC = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SD1 = 1'b1;
  logic       SD2 = 1'b1;
  logic       err;
  logic [3:0] count;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode 0 waiting for clear beams, 1 tracking, 2 faulted.
  // Within tracking, dir 1 walks the entry path, dir 2 the exit path.
  int path_en [5] = '{3, 1, 0, 2, 3};
  int path_ex [5] = '{3, 2, 0, 1, 3};
  int m_mode = 0;
  int m_dir  = 0;
  int m_pos  = 0;
  int m_cnt  = 0;
  int hist_cnt [4] = '{0, 0, 0, 0};
  int hist_err [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  lot_tracker #(.CNT_W(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .SD1   (SD1),
    .SD2   (SD2),
    .err   (err),
    .count (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int pat(input int dir, input int p);
    if (dir == 1) return path_en[p];
    return path_ex[p];
  endfunction

  task automatic model_step(input int s, output int e);
    e = 0;
    if (m_mode != 1) begin
      if (s == 3) begin m_mode = 1; m_dir = 0; m_pos = 0; end
    end else if (m_pos == 0) begin
      if (s == 3) begin end
      else if (s == path_en[1]) begin m_dir = 1; m_pos = 1; end
      else if (s == path_ex[1]) begin m_dir = 2; m_pos = 1; end
      else begin m_mode = 2; e = 1; end
    end else if (s == pat(m_dir, m_pos)) begin
    end else if (s == pat(m_dir, m_pos + 1)) begin
      m_pos++;
      if (m_pos == 4) begin
        m_pos = 0;
        if (m_dir == 1) begin
          if (m_cnt == MAXC) e = 1; else m_cnt++;
        end else begin
          if (m_cnt == 0) e = 1; else m_cnt--;
        end
      end
    end else if (s == pat(m_dir, m_pos - 1)) begin
      m_pos--;
    end else begin
      m_mode = 2;
      e = 1;
    end
  endtask

  task automatic cycle(input logic a, input logic b, input logic r);
    int e;
    @(negedge clk);
    SD1 = a;
    SD2 = b;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_mode = 0;
      m_cnt  = 0;
      for (int i = 0; i < 4; i++) begin hist_cnt[i] = 0; hist_err[i] = 0; end
    end else begin
      model_step(int'({a, b}), e);
      for (int i = 3; i > 0; i--) begin
        hist_cnt[i] = hist_cnt[i-1];
        hist_err[i] = hist_err[i-1];
      end
      hist_cnt[0] = m_cnt;
      hist_err[0] = e;
    end
    check("count", 32'(count), 32'(hist_cnt[3]));
    check("err", 32'(err), 32'(hist_err[3]));
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) cycle(a, b, 1'b0);
  endtask

  task automatic car_in(input int n);
    hold(1'b0, 1'b1, n); hold(1'b0, 1'b0, n); hold(1'b1, 1'b0, n); hold(1'b1, 1'b1, n);
  endtask

  task automatic car_out(input int n);
    hold(1'b1, 1'b0, n); hold(1'b0, 1'b0, n); hold(1'b0, 1'b1, n); hold(1'b1, 1'b1, n);
  endtask

  initial begin
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    check("reset_count", 32'(count), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    hold(1'b1, 1'b1, 4);

    // Fill past capacity, then drain past empty
    for (int k = 0; k < 17; k++) car_in(4);
    check("full_count", 32'(count), 32'd15);
    for (int k = 0; k < 17; k++) car_out(4);
    check("empty_count", 32'(count), 32'd0);

    // Back-out with five cars parked
    for (int k = 0; k < 5; k++) car_in(4);
    hold(1'b0, 1'b1, 4); hold(1'b0, 1'b0, 4); hold(1'b0, 1'b1, 4); hold(1'b1, 1'b1, 4);
    check("backout_count", 32'(count), 32'd5);

    // Both beams break together, then a clean entry
    hold(1'b0, 1'b0, 4); hold(1'b1, 1'b1, 4);
    check("double_drop_count", 32'(count), 32'd5);
    car_in(4);
    check("after_fault_entry", 32'(count), 32'd6);
    car_in(4);

    // Reset mid-transit at seven cars
    hold(1'b0, 1'b1, 4); hold(1'b0, 1'b0, 4);
    cycle(1'b0, 1'b0, 1'b1);
    hold(1'b0, 1'b0, 10);
    check("reset_mid_count", 32'(count), 32'd0);
    hold(1'b1, 1'b1, 4);
    car_in(4);
    check("post_reset_entry", 32'(count), 32'd1);

    // Exact latency from the completing SD2 rise
    hold(1'b0, 1'b1, 4); hold(1'b0, 1'b0, 4); hold(1'b1, 1'b0, 4);
    cycle(1'b1, 1'b1, 1'b0);
    check("lat_edge0", 32'(count), 32'd1);
    cycle(1'b1, 1'b1, 1'b0);
    check("lat_edge1", 32'(count), 32'd1);
    cycle(1'b1, 1'b1, 1'b0);
    check("lat_edge2", 32'(count), 32'd1);
    cycle(1'b1, 1'b1, 1'b0);
    check("lat_edge3", 32'(count), 32'd2);
    hold(1'b1, 1'b1, 3);

    // Random mix of transits, reversals, glitches and resets
    for (int k = 0; k < 250; k++) begin
      int op;
      int n;
      op = int'($urandom_range(0, 9));
      n  = int'($urandom_range(1, 3));
      case (op)
        0, 1, 2: car_in(n);
        3, 4:    car_out(n);
        5: begin hold(1'b0, 1'b1, n); hold(1'b0, 1'b0, n); hold(1'b0, 1'b1, n); hold(1'b1, 1'b1, n); end
        6: begin hold(1'b1, 1'b0, n); hold(1'b0, 1'b0, n); hold(1'b1, 1'b0, n); hold(1'b1, 1'b1, n); end
        7, 8: hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
        default: begin
          if ($urandom_range(0, 3) == 0)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
          else
            hold(1'b1, 1'b1, n);
        end
      endcase
    end
    hold(1'b1, 1'b1, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
